// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package loader_pkg;

   localparam int COUNT_W        = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int BIDX_W         = 2;

   typedef enum logic [2:0] {
      S_CNT_HI = 3'd0,
      S_CNT_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   // States in which the loader takes stream bytes
   function automatic logic is_loading(input state_t s);
      return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA) || (s == S_CSUM);
   endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Shifts stream bytes MSB-first into a 32-bit word and pulses word_valid_o
// the cycle after the fourth byte of a word lands.
module byte_word_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_last_o,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [BIDX_W-1:0] idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic              valid_q, valid_d;

   assign word_last_o  = byte_valid_i && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));
   assign word_valid_o = valid_q;
   assign word_o       = word_q;

   // Next-state for the shift register, byte index and word strobe
   always_comb begin
      idx_d   = idx_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (clr_i) begin
         idx_d = '0;
      end else if (byte_valid_i) begin
         word_d  = {word_q[23:0], byte_i};
         idx_d   = idx_q + BIDX_W'(1);
         valid_d = word_last_o;
      end else begin
         idx_d = idx_q;
      end
   end

   // Packer state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed big-endian program image into instruction memory,
// holding the CPU in reset until done. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_stream_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam logic [COUNT_W:0] DEPTH_L = DEPTH[COUNT_W:0];

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t              state_q, state_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;
   logic [COUNT_W-1:0]  wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                in_ready_q, done_q, err_q, cpu_rst_q;
   logic                done_d;
   logic                accept_s, rearm_s, word_last_s, word_valid_s;
   logic [31:0]         word_s;
   logic [COUNT_W-1:0]  n_s;

   assign accept_s = in_valid && in_ready_q;
   assign rearm_s  = start && ((state_q == S_DONE) || (state_q == S_ERR));
   assign n_s      = {cnt_q[15:8], in_data};

   byte_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (rearm_s),
      .byte_valid_i (accept_s && (state_q == S_DATA)),
      .byte_i       (in_data),
      .word_last_o  (word_last_s),
      .word_valid_o (word_valid_s),
      .word_o       (word_s)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   // Running XOR over every frame byte ahead of the checksum byte
   always_comb begin
      csum_d = csum_q;
      if (rearm_s) begin
         csum_d = 8'h00;
      end else if (accept_s && (state_q != S_CSUM)) begin
         csum_d = csum_q ^ in_data;
      end else begin
         csum_d = csum_q;
      end
   end

   // Checksum register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum_q <= 8'h00;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   // Frame FSM, word counter and write address
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      case (state_q)
         S_CNT_HI: begin
            if (accept_s) begin
               cnt_d   = {in_data, cnt_q[7:0]};
               state_d = S_CNT_LO;
            end else begin
               state_d = state_q;
            end
         end
         S_CNT_LO: begin
            if (accept_s) begin
               cnt_d = n_s;
               if ({1'b0, n_s} > DEPTH_L) begin
                  state_d = S_ERR;
               end else if (n_s == '0) begin
                  state_d = S_END;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_DATA: begin
            if (word_last_s) begin
               addr_d = wcnt_q[ADDR_W-1:0];
               wcnt_d = wcnt_q + COUNT_W'(1);
               if ((wcnt_q + COUNT_W'(1)) == cnt_q) begin
                  state_d = S_END;
               end else begin
                  state_d = state_q;
               end
            end else begin
               state_d = state_q;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept_s) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end else begin
               state_d = state_q;
            end
         end
`endif
         S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_CNT_HI;
               wcnt_d  = '0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // done waits one cycle in S_DONE so it never coincides with the last write pulse
   assign done_d = (state_q == S_DONE) && (state_d == S_DONE);

   // Control state and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_CNT_HI;
         cnt_q      <= '0;
         wcnt_q     <= '0;
         addr_q     <= '0;
         in_ready_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cpu_rst_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wcnt_q     <= wcnt_d;
         addr_q     <= addr_d;
         in_ready_q <= is_loading(state_d);
         done_q     <= done_d;
         err_q      <= (state_d == S_ERR);
         cpu_rst_q  <= ~done_d;
      end
   end

   assign in_ready = in_ready_q;
   assign im_we    = word_valid_s;
   assign im_addr  = addr_q;
   assign im_wdata = word_s;
   assign cpu_rst  = cpu_rst_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized self-checking bench for imem_stream_loader; expected writes and
// outcomes come from a frame-level model built from the image contents.
module tb_imem_stream_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   typedef logic [31:0] wlist_t[$];
   typedef struct {
      int          a;
      logic [31:0] d;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready, im_we, cpu_rst, done, err;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;

   int n_checks = 0;
   int n_errors = 0;

   wr_t  wq[$];
   int   cyc = 0;
   int   last_we_cyc = -100;
   int   done_rise_cyc = -100;
   logic prev_we = 1'b0;
   logic prev_done = 1'b0;

   imem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write-port monitor: records every pulse and checks pulse spacing
   always @(negedge clk) begin
      wr_t w;
      cyc++;
      if (im_we) begin
         check_eq("we_back_to_back", {63'd0, prev_we}, 64'd0);
         check_eq("done_with_we", {63'd0, done}, 64'd0);
         w.a = int'(im_addr);
         w.d = im_wdata;
         wq.push_back(w);
         last_we_cyc = cyc;
      end
      if (done && !prev_done) done_rise_cyc = cyc;
      prev_we   = im_we;
      prev_done = done;
   end

   task automatic send_byte(input logic [7:0] b, input int gap_mode);
      int idle;
      int t;
      idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (idle) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check_eq("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
   endtask

   task automatic run_frame(input int n_in, input wlist_t fixed, input bit bad_csum, input int gap_mode);
      logic [7:0]  fb[$];
      logic [31:0] words[$];
      logic [31:0] w;
      logic [7:0]  x;
      logic [15:0] n16;
      int          n;
      int          t;
      int          nwr;
      bit          exp_err;
      n = (fixed.size() > 0) ? fixed.size() : n_in;
      n16 = n[15:0];
      fb.push_back(n16[15:8]);
      fb.push_back(n16[7:0]);
      exp_err = (n > DEPTH);
      if (!exp_err) begin
         for (int i = 0; i < n; i++) begin
            w = (fixed.size() > 0) ? fixed[i] : $urandom;
            words.push_back(w);
            fb.push_back(w[31:24]);
            fb.push_back(w[23:16]);
            fb.push_back(w[15:8]);
            fb.push_back(w[7:0]);
         end
      end
      x = 8'h00;
      foreach (fb[i]) x = x ^ fb[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!exp_err) begin
         fb.push_back(bad_csum ? (x ^ 8'h5A) : x);
         exp_err = bad_csum;
      end
`endif
      wq.delete();
      foreach (fb[i]) send_byte(fb[i], gap_mode);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (n > DEPTH) begin
         check_eq("err_after_count", {63'd0, err}, 64'd1);
         check_eq("ready_low_on_err", {63'd0, in_ready}, 64'd0);
      end
      t = 0;
      while (!(done || err) && t < 10) begin
         @(negedge clk);
         #1;
         t++;
      end
      check_eq("frame_terminates", {63'd0, (done || err)}, 64'd1);
      repeat (2) @(negedge clk);
      #1;
      nwr = (n > DEPTH) ? 0 : n;
      check_eq("write_count", 64'(wq.size()), 64'(nwr));
      for (int i = 0; i < nwr && i < wq.size(); i++) begin
         check_eq("wr_addr", 64'(wq[i].a), 64'(i));
         check_eq("wr_data", {32'd0, wq[i].d}, {32'd0, words[i]});
      end
      check_eq("done", {63'd0, done}, {63'd0, !exp_err});
      check_eq("err", {63'd0, err}, {63'd0, exp_err});
      check_eq("cpu_rst", {63'd0, cpu_rst}, {63'd0, exp_err});
      check_eq("ready_after_frame", {63'd0, in_ready}, 64'd0);
      if (!exp_err && n > 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         check_eq("done_after_we", {63'd0, (done_rise_cyc > last_we_cyc)}, 64'd1);
`else
         check_eq("done_after_we", 64'(done_rise_cyc - last_we_cyc), 64'd1);
`endif
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq("rearm_done", {63'd0, done}, 64'd0);
      check_eq("rearm_err", {63'd0, err}, 64'd0);
      check_eq("rearm_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      check_eq("rearm_ready", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      check_eq({tag, "_cpu_rst"}, {63'd0, cpu_rst}, 64'd1);
      check_eq({tag, "_im_we"}, {63'd0, im_we}, 64'd0);
      check_eq({tag, "_im_addr"}, 64'(im_addr), 64'd0);
      check_eq({tag, "_im_wdata"}, {32'd0, im_wdata}, 64'd0);
      check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
      check_eq({tag, "_err"}, {63'd0, err}, 64'd0);
   endtask

   task automatic reset_mid_frame();
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  fb[$];
      w0 = $urandom;
      w1 = $urandom;
      fb = '{8'h00, 8'h02, w0[31:24], w0[23:16], w0[15:8], w0[7:0], w1[31:24], w1[23:16]};
      wq.delete();
      foreach (fb[i]) send_byte(fb[i], 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_values("midrst");
      repeat (3) @(negedge clk);
      check_eq("midrst_writes", 64'(wq.size()), 64'd1);
      if (wq.size() > 0) check_eq("midrst_word0", {32'd0, wq[0].d}, {32'd0, w0});
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      wlist_t none;
      wlist_t prog;
      wlist_t one;
      none = {};
      prog = '{32'h20080005, 32'h2009000C, 32'h01095020};
      one  = '{32'hAABBCCDD};

      repeat (3) @(negedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1'b1;

      run_frame(0, prog, 1'b0, 0);
      run_frame(0, prog, 1'b0, 1);
      run_frame(1025, none, 1'b0, 0);
      run_frame(0, none, 1'b0, 0);
      run_frame(0, one, 1'b0, 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
      run_frame(0, one, 1'b1, 0);
`endif
      reset_mid_frame();
      run_frame(2, none, 1'b0, 2);
      run_frame(DEPTH, none, 1'b0, 0);
      for (int k = 0; k < 12; k++) begin
         int n;
         n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(DEPTH + 1, 65535))
                                          : int'($urandom_range(0, 6));
         run_frame(n, none, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
